// File: rtl/heap_dump_ctrl.sv
// Front-end controller for a chained heap: forwards CMS updates into stage 0 and,
// on request, drains the heap through heap_read pulses into a small output FIFO.
module heap_dump_ctrl #(
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned VALUE_WIDTH = 32,
  parameter int unsigned HEAP_DEPTH  = 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [KEY_WIDTH-1:0]   upd_key,
  input  logic [VALUE_WIDTH-1:0] upd_value,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  output logic [KEY_WIDTH-1:0]   hs_key_test,
  output logic [KEY_WIDTH-1:0]   hs_key,
  output logic [VALUE_WIDTH-1:0] hs_value,
  output logic                   hs_kv_valid,
  output logic                   hs_heap_read,
  input  logic [KEY_WIDTH-1:0]   tail_key,
  input  logic [VALUE_WIDTH-1:0] tail_value,
  input  logic                   dump_start,
  output logic                   dump_busy,
  output logic                   dump_done,
  output logic [KEY_WIDTH-1:0]   rd_key,
  output logic [VALUE_WIDTH-1:0] rd_value,
  output logic                   rd_last,
  output logic                   rd_valid,
  input  logic                   rd_ready
);

  localparam int unsigned PTR_W   = (HEAP_DEPTH > 1) ? $clog2(HEAP_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(HEAP_DEPTH + 1);
  localparam int unsigned DRAIN_W = $clog2(2 * HEAP_DEPTH + 1);
  localparam int unsigned PAIRS   = HEAP_DEPTH / 2;
  localparam int unsigned PAIR_W  = $clog2(PAIRS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UPD_HOLD = 3'd1,
    S_DRAIN    = 3'd2,
    S_DUMP_A   = 3'd3,
    S_DUMP_B   = 3'd4
  } state_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    logic                   last;
  } entry_t;

  state_t               state, state_nxt;
  logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
  logic [PAIR_W-1:0]    pair_cnt, pair_nxt, pair_inc;
  logic                 ready_en;
  logic [KEY_WIDTH-1:0]   hs_key_nxt;
  logic [VALUE_WIDTH-1:0] hs_value_nxt;
  logic                 kv_valid_nxt, heap_read_nxt, busy_nxt, done_nxt;
  logic                 push, push_last, pop;
  logic                 dump_accept, upd_accept;

  entry_t               mem [HEAP_DEPTH];
  entry_t               head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 fifo_empty, fifo_full;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(HEAP_DEPTH));
  // ready_en keeps upd_ready low until the first edge after reset release
  assign upd_ready   = (state == S_IDLE) && ready_en && !dump_start;
  assign upd_accept  = upd_valid && upd_ready;
  assign dump_accept = (state == S_IDLE) && dump_start && fifo_empty;
  assign pair_inc    = pair_cnt + PAIR_W'(1);
  assign hs_key_test = hs_key;

  // State and registered outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= S_IDLE;
      drain_cnt    <= '0;
      pair_cnt     <= '0;
      ready_en     <= 1'b0;
      hs_key       <= '0;
      hs_value     <= '0;
      hs_kv_valid  <= 1'b0;
      hs_heap_read <= 1'b0;
      dump_busy    <= 1'b0;
      dump_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      drain_cnt    <= drain_nxt;
      pair_cnt     <= pair_nxt;
      ready_en     <= 1'b1;
      hs_key       <= hs_key_nxt;
      hs_value     <= hs_value_nxt;
      hs_kv_valid  <= kv_valid_nxt;
      hs_heap_read <= heap_read_nxt;
      dump_busy    <= busy_nxt;
      dump_done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (dump_accept)     state_nxt = S_DRAIN;
        else if (upd_accept) state_nxt = S_UPD_HOLD;
      end
      S_UPD_HOLD: state_nxt = S_IDLE;
      S_DRAIN:    if (drain_cnt == DRAIN_W'(1)) state_nxt = S_DUMP_A;
      S_DUMP_A:   state_nxt = S_DUMP_B;
      S_DUMP_B:   state_nxt = (pair_inc < PAIR_W'(PAIRS)) ? S_DUMP_A : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Next values of registered outputs, counters and FIFO push controls
  always_comb begin
    drain_nxt     = drain_cnt;
    pair_nxt      = pair_cnt;
    hs_key_nxt    = hs_key;
    hs_value_nxt  = hs_value;
    kv_valid_nxt  = 1'b0;
    heap_read_nxt = 1'b0;
    busy_nxt      = dump_busy;
    done_nxt      = 1'b0;
    push          = 1'b0;
    push_last     = 1'b0;
    case (state)
      S_IDLE: begin
        if (dump_accept) begin
          drain_nxt    = DRAIN_W'(2 * HEAP_DEPTH);
          pair_nxt     = '0;
          busy_nxt     = 1'b1;
          hs_key_nxt   = '0;
          hs_value_nxt = '0;
        end else if (upd_accept) begin
          hs_key_nxt   = upd_key;
          hs_value_nxt = upd_value;
          kv_valid_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        hs_key_nxt   = '0;
        hs_value_nxt = '0;
        drain_nxt    = drain_cnt - DRAIN_W'(1);
        if (drain_cnt == DRAIN_W'(1)) heap_read_nxt = 1'b1;
      end
      S_DUMP_A: begin
        hs_key_nxt   = '0;
        hs_value_nxt = '0;
        push         = 1'b1;
      end
      S_DUMP_B: begin
        hs_key_nxt   = '0;
        hs_value_nxt = '0;
        push         = 1'b1;
        pair_nxt     = pair_inc;
        if (pair_inc < PAIR_W'(PAIRS)) begin
          heap_read_nxt = 1'b1;
        end else begin
          push_last = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output FIFO of dumped entries
  assign pop  = rd_valid && rd_ready;
  assign head = mem[rd_ptr];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(HEAP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(HEAP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= '{key: tail_key, value: tail_value, last: push_last};
  end

  // Data is masked while empty so the stream reads as zero after reset
  assign rd_valid = !fifo_empty;
  assign rd_key   = rd_valid ? head.key   : '0;
  assign rd_value = rd_valid ? head.value : '0;
  assign rd_last  = rd_valid ? head.last  : 1'b0;

  a_no_overflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) !(push && fifo_full));

endmodule

// File: doc/heap_dump_ctrl.md
HEAP_DUMP_CTRL -- requirements
Module: heap_dump_ctrl

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, heap key width in bits.
REQ-002 SHALL have parameter VALUE_WIDTH, default 32, heap value width in bits.
REQ-003 SHALL have parameter HEAP_DEPTH, default 8, number of chained heap stages; even, >= 2.
REQ-004 SHALL have port ap_clk  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port ap_rst_n  in  1  reset; asynchronous and active-low.
REQ-006 SHALL have ports upd_key / upd_value  in  KEY_WIDTH / VALUE_WIDTH  update pair from the CMS estimator.
REQ-007 SHALL have ports upd_valid in 1 and upd_ready out 1, the update handshake.
REQ-008 SHALL have ports hs_key_test / hs_key  out  KEY_WIDTH  to stage 0 key_test_in / key_in.
REQ-009 SHALL have ports hs_value out VALUE_WIDTH and hs_kv_valid out 1, to stage 0 value_in / kv_in_valid.
REQ-010 SHALL have port hs_heap_read  out  1  broadcast heap_read to all stages.
REQ-011 SHALL have ports tail_key / tail_value  in  KEY_WIDTH / VALUE_WIDTH  from the last stage key_out / value_out.
REQ-012 SHALL have ports dump_start in 1 (pulse), dump_busy out 1 and dump_done out 1 (one-cycle pulse).
REQ-013 SHALL have ports rd_key / rd_value / rd_last / rd_valid out and rd_ready in, the dumped-entry stream to the AXI-lite register block.

Function
REQ-014 SHALL implement FSM states IDLE, UPD_HOLD, DRAIN, DUMP_A, DUMP_B.
REQ-015 IDLE: upd_ready=1 iff dump_start=0 that cycle; on upd_valid&upd_ready, register hs_key=hs_key_test=upd_key, hs_value=upd_value, pulse hs_kv_valid for exactly one cycle T, go UPD_HOLD.
REQ-016 UPD_HOLD: hs_key/hs_value held stable, hs_kv_valid=0, upd_ready=0; return to IDLE, so at most one update every 2 cycles.
REQ-017 dump_start SHALL be accepted in IDLE only when the output FIFO is empty; otherwise it is ignored (no state change); in the same cycle it wins over upd_valid.
REQ-018 On accepted dump_start: dump_busy=1, load a drain counter with 2*HEAP_DEPTH, go DRAIN; dump_busy stays 1 until dump_done.
REQ-019 DRAIN: decrement per cycle; hs_kv_valid=0; on reaching 0 go DUMP_A, so every stage has left V_TEST/KV_WRITE before the first heap_read.
REQ-020 In DRAIN/DUMP_A/DUMP_B, hs_key, hs_key_test and hs_value SHALL be driven 0 so zero entries bubble into the heap.
REQ-021 DUMP_A: hs_heap_read=1 for that cycle only; push {tail_key, tail_value} into the FIFO; go DUMP_B.
REQ-022 DUMP_B: hs_heap_read=0; push {tail_key, tail_value}; increment pair counter; go DUMP_A if pairs < HEAP_DEPTH/2, else pulse dump_done, clear dump_busy, go IDLE.
REQ-023 Each heap_read pulse SHALL therefore yield exactly two entries; a dump yields exactly HEAP_DEPTH entries, tail (lowest value) first.
REQ-024 The HEAP_DEPTH-entry FIFO SHALL never overflow; push while full SHALL be treated as an assertion failure.
REQ-025 rd_valid=1 while the FIFO is non-empty; an entry pops on rd_valid&rd_ready; rd_* SHALL stay stable while rd_valid&!rd_ready.
REQ-026 rd_last=1 on the HEAP_DEPTH-th entry of a dump, 0 otherwise.
REQ-027 Zero-valued entries (empty stages) SHALL be passed through unfiltered.

Reset
REQ-028 Asserting ap_rst_n=0 SHALL, immediately and at any point mid-update or mid-dump, set state IDLE, empty the FIFO, clear counters, and drive all outputs 0 (including upd_ready, hs_heap_read, dump_busy, rd_valid).
REQ-029 A dump aborted by reset SHALL NOT produce dump_done; upd_ready returns to 1 on the first clock edge after release.

Verification
REQ-030 Update timing: upd_valid key=5,val=9 -> hs_kv_valid high exactly 1 cycle, hs_key=5/hs_value=9 held 2 cycles, upd_ready low in UPD_HOLD.
REQ-031 Full dump: heap with HEAP_DEPTH=8 holding values 80..10 and rd_ready=1 -> dump_start to dump_done in 16+8 cycles, 4 heap_read pulses, 8 rd beats 10,20,...,80, rd_last on beat 8.
REQ-032 Backpressure: rd_ready=0 during dump -> FIFO fills to 8, no overflow; later rd_ready=1 drains all 8 in order.
REQ-033 Collision: dump_start and upd_valid in the same IDLE cycle -> dump accepted, update not accepted (upd_ready=0), update accepted after dump_done.
REQ-034 Blocked start: dump_start while FIFO non-empty -> ignored, dump_busy stays 0.
REQ-035 Reset mid-dump at DUMP_B of pair 2 -> all outputs 0 immediately, no dump_done, FIFO empty, new update accepted after release.
